mem_stage: RTL

- MEM stage of the 5-stage MIPS32 pipeline; consumer of the EX stage outputs (IR_ex, ALU_res, B_ex, cond).
- Registers the EX/MEM boundary and runs load/store transfers to a variable-latency data memory over a req/ack handshake.
- Reports taken branches back to IF and presents MEM/WB results (IR_mem, ALU_mem, LMD) under a valid/ready handshake.

---
 rtl/mem_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: MIPS32 MEM stage, EX/MEM capture, req/ack data memory access, branch report; MEM_TIMEOUT_EN adds access timeout
module mem_stage
`ifdef MEM_TIMEOUT_EN
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] IR_ex,
  input  logic [31:0] ALU_res,
  input  logic [31:0] B_ex,
  input  logic        cond,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] IR_mem,
  output logic [31:0] ALU_mem,
  output logic [31:0] LMD,
  output logic        br_taken,
`ifdef MEM_TIMEOUT_EN
  output logic [31:0] br_target,
  output logic        timeout_err
`else
  output logic [31:0] br_target
`endif
);
  localparam logic [5:0] OP_LW = 6'b110000, OP_SW = 6'b110001, OP_BNEQZ = 6'b110100, OP_BEQZ = 6'b110101;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic [5:0] op;
  logic accept, is_mem, is_br;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif
  assign op        = IR_ex[31:26];
  assign is_mem    = (op == OP_LW) || (op == OP_SW);
  assign is_br     = (op == OP_BNEQZ) || (op == OP_BEQZ);
  assign ex_ready  = (state == IDLE) && (!mem_valid || mem_ready);
  assign accept    = ex_valid && ex_ready;
  assign br_target = ALU_mem;
  // capture EX results, run the memory handshake and hold MEM/WB outputs until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      mem_valid <= 1'b0;
      IR_mem    <= '0;
      ALU_mem   <= '0;
      LMD       <= '0;
      br_taken  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      br_taken <= 1'b0;
      if (accept) begin
        IR_mem  <= IR_ex;
        ALU_mem <= ALU_res;
        if (is_mem) begin
          state     <= ACCESS;
          dm_req    <= 1'b1;
          dm_we     <= (op == OP_SW);
          dm_addr   <= ALU_res;
          dm_wdata  <= B_ex;
          mem_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt       <= '0;
`endif
        end else begin
          mem_valid <= 1'b1;
          br_taken  <= is_br && cond;
        end
      end else if (state == ACCESS) begin
        if (dm_ack) begin
          state     <= IDLE;
          dm_req    <= 1'b0;
          mem_valid <= 1'b1;
          if (!dm_we) LMD <= dm_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state       <= IDLE;
          dm_req      <= 1'b0;
          mem_valid   <= 1'b1;
          timeout_err <= 1'b1;
          if (!dm_we) LMD <= ERR_DATA;
        end else cnt <= cnt + CW'(1);
`endif
      end else if (mem_valid && mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end
endmodule
